pipe_skid_reg: RTL and testbench

- Generic, parametrised pipeline stage register that replaces the fixed-field per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data bundle and a control bundle between stages using a valid/ready handshake.
- Includes a 2-entry skid buffer, so a registered ready still sustains full throughput under back-pressure.
- Provides a synchronous flush for branch/hazard squash and auto-zeroes control on bubbles, so downstream sees a NOP.

---
 rtl/pipe_skid_reg.sv | 126 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Generic pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// Control is zeroed on bubbles and flushes so downstream stages always see a NOP.
module pipe_skid_reg #(
    parameter int                DATA_W   = 64,
    parameter int                CTRL_W   = 9,
    parameter logic [DATA_W-1:0] DATA_RST = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [1:0]        o_level
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              accept;
    logic              emit;
    logic              main_from_in;
    logic              main_from_skid;
    logic              skid_from_in;
    logic              skid_clear;

    // Handshake outputs decode only registered state, never the inputs.
    assign o_valid = (state != EMPTY);
    assign o_ready = (state != TWO);
    assign o_level = state;
    assign o_data  = main_data;
    assign o_ctrl  = o_valid ? main_ctrl : '0;

    assign accept = i_valid & o_ready;
    assign emit   = o_valid & i_ready;

    always_comb begin
        state_next     = state;
        main_from_in   = 1'b0;
        main_from_skid = 1'b0;
        skid_from_in   = 1'b0;
        skid_clear     = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next   = ONE;
                    main_from_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && !emit) begin
                    state_next   = TWO;
                    skid_from_in = 1'b1;
                end else if (emit && !accept) begin
                    state_next = EMPTY;
                end else if (accept && emit) begin
                    main_from_in = 1'b1;
                end
            end
            TWO: begin
                // Skid is older than any new input, so it must drain into main first.
                if (emit) begin
                    state_next     = ONE;
                    main_from_skid = 1'b1;
                    skid_clear     = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (i_flush) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_data <= DATA_RST;
            main_ctrl <= '0;
            skid_data <= DATA_RST;
            skid_ctrl <= '0;
        end else if (i_flush) begin
            main_data <= DATA_RST;
            main_ctrl <= '0;
            skid_data <= DATA_RST;
            skid_ctrl <= '0;
        end else begin
            if (main_from_in) begin
                main_data <= i_data;
                main_ctrl <= i_ctrl;
            end else if (main_from_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
            if (skid_from_in) begin
                skid_data <= i_data;
                skid_ctrl <= i_ctrl;
            end else if (skid_clear) begin
                skid_data <= DATA_RST;
                skid_ctrl <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg: reset, streaming, back-pressure,
// flush, accept+emit overlap and bubble behaviour with hand-computed expectations.
module tb_pipe_skid_reg;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 9;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              out_ready_dut;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              down_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        level;

    int checks = 0;
    int errors = 0;

    pipe_skid_reg #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .DATA_RST('0)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_flush(flush),
        .i_valid(in_valid),
        .o_ready(out_ready_dut),
        .i_data (in_data),
        .i_ctrl (in_ctrl),
        .o_valid(out_valid),
        .i_ready(down_ready),
        .o_data (out_data),
        .o_ctrl (out_ctrl),
        .o_level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within 100000 time units");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [63:0] d,
                             input logic [63:0] c, input logic [1:0] lvl, input logic rdy);
        check({tag, ".valid"}, out_valid, v);
        check({tag, ".data"}, out_data, d);
        check({tag, ".ctrl"}, out_ctrl, c);
        check({tag, ".level"}, level, lvl);
        check({tag, ".ready"}, out_ready_dut, rdy);
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_ctrl    = '0;
        down_ready = 1'b0;

        // Reset state before any clock edge
        #2;
        check_out("reset", 1'b0, 64'h0, 64'h0, 2'd0, 1'b1);
        #5;
        rst_n = 1'b1;

        // Streaming: 8 entries at full rate
        down_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            in_ctrl  = 9'h1FF;
            tick();
            check_out($sformatf("stream%0d", i), 1'b1, 64'(i), 64'h1FF, 2'd1, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        check_out("stream_drain", 1'b0, 64'h8, 64'h0, 2'd0, 1'b1);

        // Bubbles with live-looking control and undefined data on the input
        in_ctrl = 9'h1FF;
        in_data = 'x;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("bubble%0d", i), 1'b0, 64'h8, 64'h0, 2'd0, 1'b1);
        end

        // Back-pressure: A,B absorbed, C held off, then drain A,B,C,D in order
        down_ready = 1'b0;
        in_valid   = 1'b1;
        in_ctrl    = 9'h0A5;
        in_data    = 64'hA;
        tick();
        check_out("bp_a", 1'b1, 64'hA, 64'h0A5, 2'd1, 1'b1);
        in_data = 64'hB;
        tick();
        check_out("bp_b", 1'b1, 64'hA, 64'h0A5, 2'd2, 1'b0);
        in_data = 64'hC;
        tick();
        check_out("bp_hold", 1'b1, 64'hA, 64'h0A5, 2'd2, 1'b0);
        down_ready = 1'b1;
        tick();
        check_out("bp_out_b", 1'b1, 64'hB, 64'h0A5, 2'd1, 1'b1);
        tick();
        check_out("bp_out_c", 1'b1, 64'hC, 64'h0A5, 2'd1, 1'b1);
        in_data = 64'hD;
        tick();
        check_out("bp_out_d", 1'b1, 64'hD, 64'h0A5, 2'd1, 1'b1);
        in_valid = 1'b0;
        tick();
        check_out("bp_drain", 1'b0, 64'hD, 64'h0, 2'd0, 1'b1);

        // Accept and emit in the same cycle at level 1
        down_ready = 1'b0;
        in_valid   = 1'b1;
        in_data    = 64'h5;
        in_ctrl    = 9'h011;
        tick();
        check_out("ae_main5", 1'b1, 64'h5, 64'h011, 2'd1, 1'b1);
        down_ready = 1'b1;
        in_data    = 64'h6;
        in_ctrl    = 9'h022;
        tick();
        check_out("ae_main6", 1'b1, 64'h6, 64'h022, 2'd1, 1'b1);
        in_valid = 1'b0;
        tick();
        check_out("ae_drain", 1'b0, 64'h6, 64'h0, 2'd0, 1'b1);

        // Flush at level 2 with an entry offered
        down_ready = 1'b0;
        in_valid   = 1'b1;
        in_ctrl    = 9'h1FF;
        in_data    = 64'h11;
        tick();
        in_data = 64'h12;
        tick();
        check_out("fl_full", 1'b1, 64'h11, 64'h1FF, 2'd2, 1'b0);
        in_data = 64'hE;
        flush   = 1'b1;
        tick();
        check_out("fl_two", 1'b0, 64'h0, 64'h0, 2'd0, 1'b1);
        flush      = 1'b0;
        in_valid   = 1'b0;
        down_ready = 1'b1;
        tick();
        check_out("fl_after", 1'b0, 64'h0, 64'h0, 2'd0, 1'b1);

        // Flush beats an accept offered while ready
        in_valid = 1'b1;
        in_data  = 64'hE;
        flush    = 1'b1;
        tick();
        check_out("fl_empty", 1'b0, 64'h0, 64'h0, 2'd0, 1'b1);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        check_out("fl_empty_after", 1'b0, 64'h0, 64'h0, 2'd0, 1'b1);

        // Asynchronous reset mid-stream at level 2
        down_ready = 1'b0;
        in_valid   = 1'b1;
        in_ctrl    = 9'h1FF;
        in_data    = 64'h21;
        tick();
        in_data = 64'h22;
        tick();
        check_out("rst_full", 1'b1, 64'h21, 64'h1FF, 2'd2, 1'b0);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_out("rst_async", 1'b0, 64'h0, 64'h0, 2'd0, 1'b1);
        #2;
        rst_n      = 1'b1;
        in_valid   = 1'b1;
        in_data    = 64'h31;
        in_ctrl    = 9'h003;
        down_ready = 1'b1;
        tick();
        check_out("rst_first", 1'b1, 64'h31, 64'h003, 2'd1, 1'b1);
        in_valid = 1'b0;
        tick();
        check_out("rst_drain", 1'b0, 64'h31, 64'h0, 2'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
